// File: rtl/bcd_addsub_serial_if.sv
// Handshake/data bundle for bcd_addsub_serial.
// master = operand producer / result consumer; slave = the adder/subtractor.
interface bcd_addsub_serial_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  sub;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   s;
  logic                  cout;
  logic                  err;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, err
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, err
  );
endinterface

// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// IDLE -> CALC (DIGITS cycles) -> DONE (hold until out_ready) -> IDLE.
// Subtraction adds the nines' complement of B with inverted carry-in, so
// cout=1 means "no borrow" and a negative result is left in ten's complement.
// Optional macro BCD_CHECK_EN: flag any captured operand digit > 9 on err;
// when undefined err is tied low and no checking logic exists.
module bcd_addsub_serial #(
  parameter int DIGITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  bcd_addsub_serial_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [W-1:0]  a_q,     a_d;
  logic [W-1:0]  b_q,     b_d;
  logic          c_q,     c_d;
  logic [W-1:0]  s_q,     s_d;
  logic          cout_q,  cout_d;

  logic          accept;
  logic [W-1:0]  b_nine;
  logic [3:0]    a_dig, b_dig, dig;
  logic [4:0]    raw;
  logic          c_nxt;

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign accept        = bus.in_valid && (state_q == S_IDLE);

  // Nines' complement of B, digit by digit (raw value used for invalid digits).
  always_comb begin
    b_nine = '0;
    for (int i = 0; i < DIGITS; i++)
      b_nine[4*i +: 4] = 4'd9 - bus.b[4*i +: 4];
  end

  // Select the current digit pair from the captured operands.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == CW'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
  end

  // One decimal digit add with +6 correction when the binary sum exceeds 9.
  always_comb begin
    raw = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, c_q};
    if (raw > 5'd9) begin
      dig   = raw[3:0] + 4'd6;
      c_nxt = 1'b1;
    end else begin
      dig   = raw[3:0];
      c_nxt = 1'b0;
    end
  end

  // Next-state / datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    s_d     = s_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = bus.a;
          b_d     = bus.sub ? b_nine : bus.b;
          c_d     = bus.sub ? !bus.cin : bus.cin;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        for (int i = 0; i < DIGITS; i++)
          if (cnt_q == CW'(i)) s_d[4*i +: 4] = dig;
        c_d = c_nxt;
        if (cnt_q == LAST) begin
          cout_d  = c_nxt;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

`ifdef BCD_CHECK_EN
  logic err_q;
  logic bad_in;

  // Any non-decimal digit in either raw operand (before complementing).
  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if ((bus.a[4*i +: 4] > 4'd9) || (bus.b[4*i +: 4] > 4'd9)) bad_in = 1'b1;
  end

  // err is refreshed at every accept and held through CALC/DONE.
  always_ff @(posedge clk) begin
    if (rst)         err_q <= 1'b0;
    else if (accept) err_q <= bad_in;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Scoreboard bench for bcd_addsub_serial (DIGITS=4): the driver pushes the
// hand-computed result at each accept, a negedge monitor pops and compares
// on every result handshake.
module tb_bcd_addsub_serial;
  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         err;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb[$];

  bcd_addsub_serial_if #(.DIGITS(DIGITS)) bus ();

  bcd_addsub_serial #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef BCD_CHECK_EN
  localparam logic ERR_BAD = 1'b1;
`else
  localparam logic ERR_BAD = 1'b0;
`endif

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every result handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result: got s=%h cout=%b with no pending operation",
                 bus.s, bus.cout);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.s !== e.s || bus.cout !== e.cout || bus.err !== e.err) begin
          failures++;
          $display("FAIL result: got s=%h cout=%b err=%b expected s=%h cout=%b err=%b",
                   bus.s, bus.cout, bus.err, e.s, e.cout, e.err);
        end
      end
    end
  end

  // Present one operand set and hold it until accepted; optionally log the expectation.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input logic [W-1:0] es, input logic ec,
                       input logic ee, input bit push);
    int n;
    exp_t e;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    if (push) begin
      e.s = es; e.cout = ec; e.err = ee;
      sb.push_back(e);
    end
  endtask

  // Count edges after the accept edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (bus.out_valid !== 1'b1 && lat < 50);
    if (bus.out_valid !== 1'b1) begin
      checks++; failures++;
      $display("FAIL out_valid_timeout: got 0 expected 1");
    end
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                     input logic sub, input logic [W-1:0] es, input logic ec,
                     input logic ee);
    int lat;
    issue(a, b, cin, sub, es, ec, ee, 1'b1);
    wait_out(lat);
    chk("latency", W'(lat), W'(DIGITS));
    @(posedge clk); #1;
    chk("in_ready_after_result", W'(bus.in_ready), W'(1));
  endtask

  initial begin
    int lat;
    checks = 0; failures = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    chk("reset_in_ready",  W'(bus.in_ready),  W'(1));
    chk("reset_out_valid", W'(bus.out_valid), W'(0));
    chk("reset_s",         bus.s,             W'(0));
    chk("reset_cout",      W'(bus.cout),      W'(0));
    chk("reset_err",       W'(bus.err),       W'(0));

    // Additions.
    run(16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0);
    run(16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run(16'h0099, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0);
    run(16'h5555, 16'h4444, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    // Subtractions.
    run(16'h0500, 16'h0123, 1'b0, 1'b1, 16'h0377, 1'b1, 1'b0);
    run(16'h0100, 16'h0200, 1'b0, 1'b1, 16'h9900, 1'b0, 1'b0);
    run(16'h0500, 16'h0123, 1'b1, 1'b1, 16'h0376, 1'b1, 1'b0);
    run(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Back-pressure: hold DONE for 3 cycles while a new operand is offered.
    bus.out_ready = 1'b0;
    issue(16'h2468, 16'h1357, 1'b0, 1'b0, 16'h3825, 1'b0, 1'b0, 1'b1);
    wait_out(lat);
    chk("bp_latency", W'(lat), W'(DIGITS));
    for (int k = 0; k < 3; k++) begin
      bus.a = 16'h1111; bus.b = 16'h2222; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_out_valid", W'(bus.out_valid), W'(1));
      chk("bp_in_ready",  W'(bus.in_ready),  W'(0));
      chk("bp_s",         bus.s,             16'h3825);
      chk("bp_cout",      W'(bus.cout),      W'(0));
    end
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_release", W'(bus.in_ready), W'(1));
    repeat (DIGITS + 2) begin
      @(posedge clk); #1;
      chk("bp_no_phantom", W'(bus.out_valid), W'(0));
    end

    // Reset in the middle of CALC (digit 2): result discarded.
    issue(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset_in_ready",  W'(bus.in_ready),  W'(1));
    chk("midreset_out_valid", W'(bus.out_valid), W'(0));
    repeat (DIGITS + 2) begin
      @(posedge clk); #1;
      chk("midreset_no_pulse", W'(bus.out_valid), W'(0));
    end
    run(16'h4321, 16'h1234, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

    // Invalid digit: A in digit 1 adds as 10 -> 0 with carry.
    issue(16'h12A4, 16'h0000, 1'b0, 1'b0, 16'h1304, 1'b0, ERR_BAD, 1'b1);
    wait_out(lat);
    chk("bad_err_while_valid", W'(bus.err), W'(ERR_BAD));
    @(posedge clk); #1;
    // err cleared by the next clean accept.
    issue(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b1);
    chk("err_cleared_on_accept", W'(bus.err), W'(0));
    wait_out(lat);
    @(posedge clk); #1;

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", W'(sb.size()), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
